// File: rtl/network_sequencer_pkg.sv
// Shared definitions for the layer sequencer: default geometry, bus widths
// and the sequencer state encoding.
package network_sequencer_pkg;

  localparam int unsigned NET_LAYERS  = 3;
  localparam int unsigned NET_TIMEOUT = 4095;
  localparam int unsigned ROM_AW      = 11;
  localparam int unsigned MAC_LANES   = 128;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    NEXT,
    FIN,
    ERR
  } seq_state_t;

endpackage

// File: rtl/network_sequencer_if.sv
// Handshake, per-layer status and shared-resource buses between the
// sequencer (slave side) and the surrounding network datapath (master side).
interface network_sequencer_if
  import network_sequencer_pkg::*;
#(
  parameter int unsigned BIT    = 16,
  parameter int unsigned LAYERS = NET_LAYERS
);

  logic                            start;
  logic [LAYERS-1:0]               layer_done;
  logic [LAYERS-1:0]               layer_overflow;
  logic [LAYERS*ROM_AW-1:0]        layer_addr;
  logic [LAYERS*MAC_LANES*BIT-1:0] layer_opr1;
  logic [LAYERS*MAC_LANES*BIT-1:0] layer_opr2;
  logic [LAYERS-1:0]               layer_ena;
  logic [LAYERS-1:0]               layer_rst_n;
  logic [ROM_AW-1:0]               addr_to_rom;
  logic [MAC_LANES*BIT-1:0]        opr1_to_MultAdder;
  logic [MAC_LANES*BIT-1:0]        opr2_to_MultAdder;
  logic                            busy;
  logic                            done;
  logic                            overflow;
  logic                            timeout;
  logic [1:0]                      cur_layer;

  modport slave (
    input  start, layer_done, layer_overflow, layer_addr, layer_opr1, layer_opr2,
    output layer_ena, layer_rst_n, addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder,
    output busy, done, overflow, timeout, cur_layer
  );

  modport master (
    output start, layer_done, layer_overflow, layer_addr, layer_opr1, layer_opr2,
    input  layer_ena, layer_rst_n, addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder,
    input  busy, done, overflow, timeout, cur_layer
  );

endinterface

// File: rtl/layer_bus_mux.sv
// Selects one layer's slice of a concatenated bus onto a shared resource;
// drives zero when no layer owns the resource.
module layer_bus_mux #(
  parameter int unsigned LAYERS = 3,
  parameter int unsigned WIDTH  = 11
) (
  input  logic [1:0]              sel,
  input  logic                    en,
  input  logic [LAYERS*WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0]        bus_out
);

  always_comb begin
    bus_out = '0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (en && (sel == 2'(i))) bus_out = bus_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Runs the layer blocks one after another: reset pulse, run under a
// watchdog, one-cycle handover gap, then the next layer.
module network_sequencer
  import network_sequencer_pkg::*;
#(
  parameter int unsigned BIT     = 16,
  parameter int unsigned LAYERS  = NET_LAYERS,
  parameter int unsigned TIMEOUT = NET_TIMEOUT
) (
  input logic                clk,
  input logic                iRst,
  network_sequencer_if.slave bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam int unsigned OPW  = MAC_LANES * BIT;

  seq_state_t        state;
  logic              rst_phase;
  logic [WD_W-1:0]   wd;
  logic [1:0]        cur;
  logic [LAYERS-1:0] ena_q;
  logic [LAYERS-1:0] rst_n_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic              to_q;
  logic              cur_done;
  logic              cur_ovf;
  logic              bus_en;

  function automatic logic [LAYERS-1:0] layer_sel(input logic [1:0] idx);
    layer_sel = '0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (idx == 2'(i)) layer_sel[i] = 1'b1;
    end
  endfunction

  // Equality select keeps X/Z on inactive layers' flags from reaching the FSM.
  always_comb begin
    cur_done = 1'b0;
    cur_ovf  = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (cur == 2'(i)) begin
        cur_done = bus.layer_done[i];
        cur_ovf  = bus.layer_overflow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      cur       <= '0;
      rst_phase <= 1'b0;
      wd        <= '0;
      ena_q     <= '0;
      rst_n_q   <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN, ERR: begin
          if (bus.start) begin
            state     <= RST;
            cur       <= '0;
            rst_phase <= 1'b0;
            ena_q     <= layer_sel(2'd0);
            rst_n_q   <= ~layer_sel(2'd0);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
          end
        end
        RST: begin
          if (rst_phase) begin
            state   <= RUN;
            rst_n_q <= '1;
            wd      <= '0;
          end else begin
            rst_phase <= 1'b1;
          end
        end
        RUN: begin
          ovf_q <= ovf_q | cur_ovf;
          // Done is checked first so a done arriving with watchdog expiry wins.
          if (cur_done) begin
            ena_q <= '0;
            if (cur == 2'(LAYERS - 1)) begin
              state  <= FIN;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state <= NEXT;
            end
          end else begin
            wd <= wd + WD_W'(1);
            if (wd == WD_W'(TIMEOUT - 1)) begin
              state  <= ERR;
              to_q   <= 1'b1;
              busy_q <= 1'b0;
              ena_q  <= '0;
            end
          end
        end
        NEXT: begin
          state     <= RST;
          cur       <= cur + 2'd1;
          rst_phase <= 1'b0;
          ena_q     <= layer_sel(cur + 2'd1);
          rst_n_q   <= ~layer_sel(cur + 2'd1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_en          = (state == RST) || (state == RUN);
  assign bus.layer_ena   = ena_q;
  assign bus.layer_rst_n = rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.timeout     = to_q;
  assign bus.cur_layer   = cur;

  layer_bus_mux #(.LAYERS(LAYERS), .WIDTH(ROM_AW)) u_addr_mux (
    .sel(cur), .en(bus_en), .bus_in(bus.layer_addr), .bus_out(bus.addr_to_rom)
  );

  layer_bus_mux #(.LAYERS(LAYERS), .WIDTH(OPW)) u_opr1_mux (
    .sel(cur), .en(bus_en), .bus_in(bus.layer_opr1), .bus_out(bus.opr1_to_MultAdder)
  );

  layer_bus_mux #(.LAYERS(LAYERS), .WIDTH(OPW)) u_opr2_mux (
    .sel(cur), .en(bus_en), .bus_in(bus.layer_opr2), .bus_out(bus.opr2_to_MultAdder)
  );

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: cycle table, watchdog, done/timeout
// race, asynchronous reset and a full three-layer run with stub layers.
module tb_network_sequencer;
  import network_sequencer_pkg::*;

  localparam int unsigned BIT    = 16;
  localparam int unsigned LAYERS = 3;
  localparam int unsigned TO     = 50;
  localparam int unsigned W      = MAC_LANES * BIT;

  logic clk = 1'b0;
  logic iRst;
  always #5 clk = ~clk;

  network_sequencer_if #(.BIT(BIT), .LAYERS(LAYERS)) bus ();

  network_sequencer #(.BIT(BIT), .LAYERS(LAYERS), .TIMEOUT(TO)) dut (
    .clk(clk), .iRst(iRst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic       stub_mode;
  logic [2:0] vec_done, vec_ovf;
  logic [2:0] stub_done, stub_ovf;
  int         cnt [3] = '{0, 0, 0};
  logic [10:0] addr_c [3] = '{11'h401, 11'h40b, 11'h123};

  // Stub layers: count enabled cycles since their reset, done after 20 run cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!bus.layer_rst_n[i]) cnt[i] <= 0;
      else if (bus.layer_ena[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    stub_done = '0;
    for (int i = 0; i < 3; i++)
      stub_done[i] = bus.layer_ena[i] && bus.layer_rst_n[i] && (cnt[i] == 19);
    stub_ovf[0] = bus.layer_ena[0] ? 1'b0 : 1'b1;
    stub_ovf[1] = bus.layer_ena[1] && bus.layer_rst_n[1] && (cnt[1] == 5);
    stub_ovf[2] = 1'b0;
  end

  assign bus.layer_done     = stub_mode ? stub_done : vec_done;
  assign bus.layer_overflow = stub_mode ? stub_ovf  : vec_ovf;

  function automatic logic [W-1:0] pat(input int which, input int lay);
    logic [W-1:0]   r;
    logic [BIT-1:0] v;
    v = BIT'(32'hA5C3 ^ (which * 32'h1111) ^ (lay * 32'h0707));
    for (int l = 0; l < int'(MAC_LANES); l++) r[l*BIT +: BIT] = v + BIT'(l);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sel 0..2 = layer owning the shared buses, 3 = buses must be zero
  task automatic chk_out(input string tag, input logic [2:0] e_ena, input logic [2:0] e_rstn,
                         input logic e_busy, input logic e_done, input logic e_ovf,
                         input logic e_to, input logic [1:0] e_cur, input int e_sel);
    logic [W-1:0] eo1, eo2;
    logic [10:0]  ea;
    chk({tag, ".ctl"},
        64'({bus.layer_ena, bus.layer_rst_n, bus.busy, bus.done, bus.overflow, bus.timeout, bus.cur_layer}),
        64'({e_ena, e_rstn, e_busy, e_done, e_ovf, e_to, e_cur}));
    ea = '0; eo1 = '0; eo2 = '0;
    if (e_sel < 3) begin
      ea = addr_c[e_sel]; eo1 = pat(1, e_sel); eo2 = pat(2, e_sel);
    end
    tests++;
    if (bus.addr_to_rom !== ea || bus.opr1_to_MultAdder !== eo1 || bus.opr2_to_MultAdder !== eo2) begin
      fails++;
      $display("FAIL %s.bus: got addr %0h op1[15:0] %0h op2[15:0] %0h expected addr %0h op1[15:0] %0h op2[15:0] %0h",
               tag, bus.addr_to_rom, bus.opr1_to_MultAdder[15:0], bus.opr2_to_MultAdder[15:0],
               ea, eo1[15:0], eo2[15:0]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic [2:0] done_in;
    logic [2:0] ovf_in;
    logic [2:0] ena;
    logic [2:0] rst_n;
    logic       busy;
    logic       dn;
    logic       ov;
    logic       to;
    logic [1:0] cur;
    int         sel;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [5:0] stub_exp(input int n);
    logic [2:0] e;
    if (n <= 21)      e = 3'b001;
    else if (n == 22) e = 3'b000;
    else if (n <= 44) e = 3'b010;
    else if (n == 45) e = 3'b000;
    else if (n <= 67) e = 3'b100;
    else              e = 3'b000;
    return {e, logic'(n < 68), logic'(n >= 68), logic'(n >= 31)};
  endfunction

  initial begin
    int hold_bad;
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0};
    tbl[1]  = '{1'b0, 3'b000, 3'b000, 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0};
    tbl[2]  = '{1'b0, 3'b000, 3'b000, 3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0};
    tbl[3]  = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3};
    tbl[4]  = '{1'b1, 3'b000, 3'b000, 3'b010, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1};
    tbl[5]  = '{1'b0, 3'b000, 3'b010, 3'b010, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1};
    tbl[7]  = '{1'b0, 3'b001, 3'b010, 3'b010, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1};
    tbl[8]  = '{1'b0, 3'b010, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3};
    tbl[9]  = '{1'b0, 3'b000, 3'b000, 3'b100, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 3'b100, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 3'b100, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2};
    tbl[12] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3};
    tbl[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3};
    tbl[14] = '{1'b1, 3'b000, 3'b000, 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0};

    iRst = 1'b1; stub_mode = 1'b0; vec_done = '0; vec_ovf = '0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.layer_addr[i*ROM_AW +: ROM_AW] = addr_c[i];
      bus.layer_opr1[i*W +: W] = pat(1, i);
      bus.layer_opr2[i*W +: W] = pat(2, i);
    end
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    #2 iRst = 1'b0;
    step;
    chk_out("idle", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3);

    for (int r = 0; r < 15; r++) begin
      bus.start = tbl[r].start; vec_done = tbl[r].done_in; vec_ovf = tbl[r].ovf_in;
      step;
      chk_out($sformatf("row%0d", r), tbl[r].ena, tbl[r].rst_n, tbl[r].busy, tbl[r].dn,
              tbl[r].ov, tbl[r].to, tbl[r].cur, tbl[r].sel);
    end
    bus.start = 1'b0; vec_done = '0; vec_ovf = '0;

    // Watchdog: layer 1 never finishes, expect exactly TO run cycles.
    step; chk_out("b_rst2", 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    step; chk_out("b_run0", 3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    vec_done = 3'b001; step; vec_done = '0;
    chk_out("b_next", 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    step; step; step;
    chk_out("b_run1", 3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1);
    hold_bad = 0;
    for (int k = 1; k < int'(TO); k++) begin
      step;
      if (bus.layer_ena !== 3'b010 || bus.timeout !== 1'b0) hold_bad++;
    end
    chk("b_hold", 64'(hold_bad), 64'd0);
    step; chk_out("b_err", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3);
    step; chk_out("b_err_hold", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3);
    bus.start = 1'b1; step; bus.start = 1'b0;
    chk_out("b_restart", 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0);

    // Done coincides with watchdog expiry while start is held: done wins.
    step; step;
    repeat (int'(TO) - 1) step;
    vec_done = 3'b001; bus.start = 1'b1; step; vec_done = '0; bus.start = 1'b0;
    chk_out("c_done_wins", 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    step; chk_out("c_rst1", 3'b010, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1);

    // Asynchronous reset between edges during layer 1 run.
    step; step; step;
    chk_out("d_run", 3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1);
    #2 iRst = 1'b1;
    #1 chk_out("d_async", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    #2 iRst = 1'b0;
    bus.start = 1'b1; step; bus.start = 1'b0;
    chk_out("d_first_start", 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0);

    // Full run with stub layers; layer 0 drives junk overflow while inactive.
    iRst = 1'b1; #3 iRst = 1'b0;
    stub_mode = 1'b1;
    bus.start = 1'b1; step; bus.start = 1'b0;
    for (int n = 0; n < 72; n++) begin
      chk($sformatf("e_cyc%0d", n),
          64'({bus.layer_ena, bus.busy, bus.done, bus.overflow}), 64'(stub_exp(n)));
      step;
    end
    chk_out("e_fin", 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3);
    iRst = 1'b1;
    #1 chk_out("e_reset", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    iRst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
